// File: rtl/tt_pkg.sv
// Shared types and helpers for the exhaustive-vector response checker.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } tt_state_e;

  localparam int TT_N_IN_DEFAULT = 5;

  function automatic int tt_width(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clear has priority.
module tt_sat_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/tt_response_checker.sv
// Captures (vector, response) beats into a truth table, tracks coverage and
// compares against a golden table; reports done/pass and the first failure.
module tt_response_checker
  import tt_pkg::*;
#(
  parameter  int N_IN = TT_N_IN_DEFAULT,
  localparam int TT_W = tt_width(N_IN),
  localparam int CW   = $clog2(TT_W) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            vec_valid,
  input  logic [N_IN-1:0] vec_in,
  input  logic            resp_in,
  input  logic [TT_W-1:0] expected,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [CW-1:0]   mismatch_cnt,
  output logic            dup_err,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output logic [TT_W-1:0] truth_table
);

  tt_state_e       state_q, state_d;
  logic [TT_W-1:0] cov_q, cov_d;
  logic [TT_W-1:0] tt_q, tt_d;
  logic            dup_q, dup_d;
  logic            ffv_q, ffv_d;
  logic [N_IN-1:0] ffvec_q, ffvec_d;

  logic [TT_W-1:0] onehot;
  logic            beat;
  logic            mism;

  // A start in the same cycle as a beat wins: the beat is discarded.
  assign beat = (state_q == CAPTURE) && vec_valid && !start;
  assign mism = (resp_in != expected[vec_in]);

  always_comb begin
    onehot         = '0;
    onehot[vec_in] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = CAPTURE;
      CAPTURE: begin
        if (start) begin
          state_d = CAPTURE;
        end else if (vec_valid && ((cov_q | onehot) == '1)) begin
          state_d = DONE;
        end
      end
      DONE:    if (start) state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cov_d   = cov_q;
    tt_d    = tt_q;
    dup_d   = dup_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;
    if (start) begin
      cov_d   = '0;
      tt_d    = '0;
      dup_d   = 1'b0;
      ffv_d   = 1'b0;
      ffvec_d = '0;
    end else if (beat) begin
      tt_d[vec_in] = resp_in;
      cov_d        = cov_q | onehot;
      if (cov_q[vec_in]) dup_d = 1'b1;
      if (mism && !ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = vec_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cov_q   <= '0;
      tt_q    <= '0;
      dup_q   <= 1'b0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
    end else begin
      state_q <= state_d;
      cov_q   <= cov_d;
      tt_q    <= tt_d;
      dup_q   <= dup_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  tt_sat_counter #(
    .W(CW)
  ) u_mis_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (start),
    .inc_i (beat && mism),
    .cnt_o (mismatch_cnt)
  );

  assign busy             = (state_q == CAPTURE);
  assign done             = (state_q == DONE);
  assign pass             = done && (mismatch_cnt == '0);
  assign dup_err          = dup_q;
  assign first_fail_valid = ffv_q;
  assign first_fail_vec   = ffvec_q;
  assign truth_table      = tt_q;

endmodule

// File: doc/tt_response_checker.md
Name: tt_response_checker

Overview:
- Receiving end of the exhaustive-vector test flow. Samples (input vector, DUT response) pairs from a stimulus source.
- Builds the captured truth table and tracks which vectors have been covered.
- Compares each response against an expected truth-table word.
- Reports done/pass, mismatch count and first failing vector. This makes lab combinational blocks self-checking on hardware as well as in simulation.

Parameters:
- N_IN, 5, number of DUT inputs (vector width).
- TT_W, 2**N_IN, truth-table width (localparam, derived, not overridable).
- CW, $clog2(TT_W)+1, mismatch-counter width (localparam).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse: clear state, begin capture.
- vec_valid  in  1  vec_in/resp_in valid this cycle.
- vec_in  in  N_IN  applied input vector (bit N_IN-1 = first DUT input, e.g. a).
- resp_in  in  1  DUT output for vec_in.
- expected  in  TT_W  golden truth table; bit k = expected output for vector k. Sampled per beat, must be stable during capture.
- busy  out  1  high in CAPTURE.
- done  out  1  high in DONE.
- pass  out  1  valid when done; 1 iff mismatch_cnt==0.
- mismatch_cnt  out  CW  count of mismatching beats, saturates at all-ones.
- dup_err  out  1  sticky: a vector arrived that was already covered.
- first_fail_valid  out  1  sticky: at least one mismatch seen.
- first_fail_vec  out  N_IN  vector of first mismatch.
- truth_table  out  TT_W  captured responses; bit k = last resp_in for vector k.

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; all outputs 0, including the coverage bitmap, truth_table, mismatch_cnt, dup_err, first_fail_*. rst overrides start and vec_valid.
- FSM states:
  - IDLE: start -> CAPTURE, clearing coverage, truth_table, mismatch_cnt, dup_err and first_fail_*. vec_valid is ignored.
  - CAPTURE: on each vec_valid beat, with k = vec_in:
    - truth_table[k] <= resp_in
    - cov[k] <= 1
    - if cov[k] was already 1: dup_err <= 1 (entry overwritten)
    - if resp_in != expected[k]: mismatch_cnt++ (saturating). If first_fail_valid==0, set first_fail_valid and first_fail_vec <= k.
    - If (cov | onehot(k)) becomes all-ones, go to DONE on the same edge. The final beat's updates are committed.
  - DONE: done=1, pass = (mismatch_cnt==0). All results hold, and vec_valid is ignored. start -> CAPTURE with a full clear.
- start while in CAPTURE: restart, same clear as from IDLE. A vec_valid in that same cycle is discarded.
- Latency:
  - Each beat's result is visible on outputs the cycle after the sampling edge.
  - done rises the cycle after the beat that completes coverage.
  - Throughput: one beat per cycle, with no backpressure.
- A duplicate does not affect the coverage count. Mismatches on duplicates are still counted.
- pass is not gated by dup_err; a consumer may check both.
- Output timing:
  - busy and done are registered and mutually exclusive.
  - pass is 0 whenever done=0.

Decomposition:
- Shared package tt_pkg holds:
  - state enum (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2)
  - default N_IN constant
  - function tt_width(n)
- One natural sub-module: tt_sat_counter, a width-parameterised saturating counter with clear/inc, instantiated for mismatch_cnt.
- Everything else stays in tt_response_checker.

Test Plan:
- Reset: rst=1 for 2 cycles with vec_valid=1 -> all outputs 0 and state IDLE. After release with no start, beats are ignored (truth_table stays 0).
- Clean sweep: start, then 32 beats k=0..31, resp=expected[k], expected=32'hF0F0_F00F -> done=1 one cycle after beat 31. pass=1, mismatch_cnt=0, truth_table=32'hF0F0_F00F, dup_err=0.
- Faults: same sweep with resp inverted at k=5 and k=20 -> mismatch_cnt=2, first_fail_vec=5'd5, first_fail_valid=1, pass=0. truth_table equals expected with bits 5 and 20 flipped.
- Out of order and duplicate: beats in order 31 down to 0, with k=7 sent twice (mid-stream) -> dup_err=1. done after the 33rd beat, and truth_table[7] equals the second response.
- Restart: start asserted after 10 beats with vec_valid=1 in the same cycle -> counters and coverage cleared, and that beat is discarded. A full 32-beat sweep is then needed for done.
- Saturation, N_IN=2 (TT_W=4, CW=3): sweep with all mismatches plus 5 duplicate mismatching beats before the last vector -> mismatch_cnt=3'd7 (saturated), done=1, pass=0.
